// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline stage register for any boundary (IF/ID, ID/EX, EX/MEM,
//   MEM/WB). Carries a DATA_W payload and a CTRL_W control vector under a
//   valid/ready handshake. A 2-entry skid buffer (main + skid) sustains one
//   transfer per cycle while in_ready is driven purely from a flop, so there is
//   no combinational path from out_ready to in_ready.
//
//   Optional feature macro: PIPE_STAGE_PERF_EN
//     defined   -> stall_cnt counts cycles with out_valid=1 & out_ready=0,
//                  saturating at all-ones; cleared only by reset.
//     undefined -> no counter flops, stall_cnt tied to 0.
//
// Ports:
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous, active-low reset
//   in_valid   in   1       upstream entry present
//   in_ready   out  1       stage can accept (= ~skid valid, from a flop)
//   in_data    in   DATA_W  upstream payload
//   in_ctrl    in   CTRL_W  upstream control
//   flush      in   1       synchronous squash of all held entries
//   out_valid  out  1       main entry valid
//   out_ready  in   1       downstream accepts
//   out_data   out  DATA_W  main payload
//   out_ctrl   out  CTRL_W  main control, 0 whenever out_valid=0
//   occupancy  out  2       number of held entries, 0..2
//   stall_cnt  out  CNT_W   back-pressure cycle count
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CTRL_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              r_main_v;
   logic [DATA_W-1:0] r_main_data;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic              r_skid_v;
   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_skid_ctrl;

   logic              w_accept;
   logic              w_pop;

   // in_ready depends only on the skid flop: a full stage refuses input.
   assign in_ready  = ~r_skid_v;
   assign w_accept  = in_valid & ~r_skid_v;
   assign w_pop     = r_main_v & out_ready;

   assign out_valid = r_main_v;
   assign out_data  = r_main_data;
   assign out_ctrl  = r_main_ctrl;
   assign occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};

   // Control flops load in_ctrl only alongside a valid load; every
   // invalidation writes 0, so out_ctrl is never nonzero while out_valid=0.
   // Data flops are never cleared except by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_main_v    <= 1'b0;
         r_main_data <= '0;
         r_main_ctrl <= '0;
         r_skid_v    <= 1'b0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
      end else if (flush) begin
         // Squash both entries; any input this cycle is dropped. A pop in
         // this cycle already completed downstream from the visible main.
         r_main_v    <= 1'b0;
         r_main_ctrl <= '0;
         r_skid_v    <= 1'b0;
         r_skid_ctrl <= '0;
      end else if (!r_main_v) begin
         // Empty: skid is necessarily empty too.
         if (w_accept) begin
            r_main_v    <= 1'b1;
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
         end
      end else if (!r_skid_v) begin
         // One entry held.
         if (w_pop && w_accept) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
         end else if (w_pop) begin
            r_main_v    <= 1'b0;
            r_main_ctrl <= '0;
         end else if (w_accept) begin
            r_skid_v    <= 1'b1;
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
         end
      end else begin
         // Full: in_ready=0, so only a pop changes state; the older main
         // leaves and the skid entry advances, preserving FIFO order.
         if (w_pop) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_skid_v    <= 1'b0;
            r_skid_ctrl <= '0;
         end
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;

   // Saturating back-pressure counter; flush leaves it untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (r_main_v && !out_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned CTRL_W = 8;
   localparam int unsigned CNT_W  = 4;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;

   int unsigned n_tests;
   int unsigned n_fail;

   pipe_stage_skid #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_ctrl  (in_ctrl),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ctrl (out_ctrl),
      .occupancy(occupancy),
      .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] c);
      in_valid = v;
      in_data  = d;
      in_ctrl  = c;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 64'h0, 8'h0);

      // Reset values
      #1;
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data",  64'(out_data),  64'd0);
      chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
      chk("rst_occ",       64'(occupancy), 64'd0);
      chk("rst_stall",     64'(stall_cnt), 64'd0);
      #11;
      rst = 1'b1;

      // Single transfer, latency 1
      out_ready = 1'b1;
      drive(1'b1, 64'h1234, 8'h05);
      #1;
      chk("t1_in_ready_pre", 64'(in_ready), 64'd1);
      tick();
      drive(1'b0, 64'h0, 8'h0);
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_out_data",  64'(out_data),  64'h1234);
      chk("t1_out_ctrl",  64'(out_ctrl),  64'h05);
      chk("t1_occ",       64'(occupancy), 64'd1);
      chk("t1_in_ready",  64'(in_ready),  64'd1);
      tick();
      chk("t1_drain_valid", 64'(out_valid), 64'd0);
      chk("t1_drain_ctrl",  64'(out_ctrl),  64'd0);
      chk("t1_drain_occ",   64'(occupancy), 64'd0);

      // Streaming 1..8, no bubbles
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 64'(i), 8'(i));
         tick();
         chk("stream_valid",    64'(out_valid), 64'd1);
         chk("stream_data",     64'(out_data),  64'(i));
         chk("stream_ctrl",     64'(out_ctrl),  64'(i));
         chk("stream_in_ready", 64'(in_ready),  64'd1);
      end
      drive(1'b0, 64'h0, 8'h0);
      tick();
      chk("stream_end_valid", 64'(out_valid), 64'd0);

      // Back-pressure: A, B fill the stage, C is held upstream
      out_ready = 1'b0;
      drive(1'b1, 64'hA, 8'hA1);
      tick();
      chk("bp_a_occ",  64'(occupancy), 64'd1);
      chk("bp_a_data", 64'(out_data),  64'hA);
      drive(1'b1, 64'hB, 8'hB2);
      tick();
      chk("bp_b_occ",      64'(occupancy), 64'd2);
      chk("bp_b_in_ready", 64'(in_ready),  64'd0);
      chk("bp_b_data",     64'(out_data),  64'hA);
      drive(1'b1, 64'hC, 8'hC3);
      tick();
      chk("bp_c_held_occ",  64'(occupancy), 64'd2);
      chk("bp_c_held_data", 64'(out_data),  64'hA);
      chk("bp_c_held_rdy",  64'(in_ready),  64'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_pop1_data",  64'(out_data),  64'hB);
      chk("bp_pop1_ctrl",  64'(out_ctrl),  64'hB2);
      chk("bp_pop1_occ",   64'(occupancy), 64'd1);
      chk("bp_pop1_ready", 64'(in_ready),  64'd1);
      tick();
      drive(1'b0, 64'h0, 8'h0);
      chk("bp_pop2_data",  64'(out_data),  64'hC);
      chk("bp_pop2_ctrl",  64'(out_ctrl),  64'hC3);
      chk("bp_pop2_valid", 64'(out_valid), 64'd1);
      tick();
      chk("bp_drain_valid", 64'(out_valid), 64'd0);
      chk("bp_drain_occ",   64'(occupancy), 64'd0);

      // Flush at occupancy 2 with D offered
      out_ready = 1'b0;
      drive(1'b1, 64'h11, 8'h11);
      tick();
      drive(1'b1, 64'h22, 8'h22);
      tick();
      chk("fl_pre_occ", 64'(occupancy), 64'd2);
      drive(1'b1, 64'hDD, 8'hDD);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 64'h0, 8'h0);
      chk("fl_valid",    64'(out_valid), 64'd0);
      chk("fl_ctrl",     64'(out_ctrl),  64'd0);
      chk("fl_occ",      64'(occupancy), 64'd0);
      chk("fl_in_ready", 64'(in_ready),  64'd1);
      chk("fl_data_hold", 64'(out_data), 64'h11);
      out_ready = 1'b1;
      tick();
      chk("fl_no_d_valid", 64'(out_valid), 64'd0);

      // Flush while empty: input dropped even though in_ready=1
      drive(1'b1, 64'hEE, 8'hEE);
      flush = 1'b1;
      #1;
      chk("fl2_in_ready", 64'(in_ready), 64'd1);
      tick();
      flush = 1'b0;
      drive(1'b0, 64'h0, 8'h0);
      chk("fl2_valid", 64'(out_valid), 64'd0);
      chk("fl2_occ",   64'(occupancy), 64'd0);

      // Stall counter: hold one entry for 20 cycles without out_ready
      out_ready = 1'b0;
      drive(1'b1, 64'h77, 8'h77);
      tick();
      drive(1'b0, 64'h0, 8'h0);
      for (int i = 0; i < 20; i++) tick();
`ifdef PIPE_STAGE_PERF_EN
      chk("perf_sat", 64'(stall_cnt), 64'hF);
`else
      chk("perf_tied", 64'(stall_cnt), 64'h0);
`endif
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("perf_flush_valid", 64'(out_valid), 64'd0);
`ifdef PIPE_STAGE_PERF_EN
      chk("perf_after_flush", 64'(stall_cnt), 64'hF);
`else
      chk("perf_after_flush", 64'(stall_cnt), 64'h0);
`endif

      // Async reset mid-stream, off the clock edge
      drive(1'b1, 64'h99, 8'h99);
      tick();
      drive(1'b1, 64'h9A, 8'h9A);
      tick();
      drive(1'b0, 64'h0, 8'h0);
      chk("ar_pre_occ", 64'(occupancy), 64'd2);
      #1;
      rst = 1'b0;
      #1;
      chk("ar_valid",    64'(out_valid), 64'd0);
      chk("ar_occ",      64'(occupancy), 64'd0);
      chk("ar_ctrl",     64'(out_ctrl),  64'd0);
      chk("ar_data",     64'(out_data),  64'd0);
      chk("ar_in_ready", 64'(in_ready),  64'd1);
      chk("ar_stall",    64'(stall_cnt), 64'd0);
      #4;
      rst = 1'b1;
      tick();
      chk("ar_post_valid", 64'(out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time guard so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers: one generic pipeline stage for any boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a DATA_W payload and a CTRL_W control vector with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with registered in_ready, so there is no combinational path from out_ready to in_ready.
- Synchronous flush replaces the per-field nop gating: squashed entries become bubbles with all control bits zero.

Parameters:
- DATA_W, 64, payload width (operands, immediates, PC+2, register selects); never cleared by flush.
- CTRL_W, 8, side-effecting control bits (RegWrite, MemWrite, MemRead, halt, createdump...); forced to 0 for invalid/flushed entries.
- CNT_W, 16, width of the stall counter (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; equals ~skid_v, driven from a flop only.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control.
- flush  in  1  synchronous squash of all held entries.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main payload.
- out_ctrl  out  CTRL_W  main control; 0 whenever out_valid=0.
- occupancy  out  2  number of held entries, 0..2.
- stall_cnt  out  CNT_W  back-pressure cycle count (optional feature only).

Behaviour:
- Storage: main entry {main_v, main_data, main_ctrl} and skid entry {skid_v, skid_data, skid_ctrl}.
  - out_* come from the main entry.
  - occupancy = main_v + skid_v.
  - State (main_v=0, skid_v=1) is unreachable.
- Reset (rst=0, async): main_v=0, skid_v=0, all data/ctrl flops 0, stall_cnt 0. Outputs during reset: in_ready=1, out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
- Handshakes: accept = in_valid & in_ready; pop = out_valid & out_ready. Upstream must hold in_data/in_ctrl stable while in_valid=1 and in_ready=0.
- Next-state per rising edge, flush=0:
  - Empty (0,0): accept -> main loaded, next (1,0). Latency 1 cycle.
  - One (1,0), pop & accept -> main reloaded, stays (1,0). Throughput 1/cycle.
  - One (1,0), pop & no accept -> (0,0).
  - One (1,0), no pop & accept -> skid loaded, next (1,1).
  - One (1,0), no pop & no accept -> hold.
  - Full (1,1): in_ready=0. pop -> skid moves to main, skid_v=0, next (1,0); no pop -> hold.
- Ordering: strict FIFO. The skid entry is always younger than the main entry.
- Flush (highest priority):
  - Next edge gives main_v=skid_v=0 and main_ctrl=skid_ctrl=0; data flops hold their values.
  - An input presented in the same cycle is dropped, even if in_ready=1.
  - A pop in the same cycle still completes downstream for the current main entry, which is already visible.
- Ctrl gating: ctrl flops load in_ctrl only on a valid load; any invalidation (pop without refill, flush) writes 0. out_ctrl is therefore never nonzero with out_valid=0.
- Reset mid-operation clears everything immediately; any entry held at that time is lost.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with out_valid=1 & out_ready=0.
  - It saturates at all-ones (no wrap).
  - Flush does not clear it; only reset clears it.
- Undefined: no counter flops; stall_cnt is tied to 0.

Test Plan:
- Reset then in_valid=1, in_data=0x1234, in_ctrl=0x05, out_ready=1 -> next cycle out_valid=1, out_data=0x1234, out_ctrl=0x05, occupancy=1; in_ready=1 throughout.
- Streaming: 8 back-to-back inputs 1..8 with out_ready=1 -> outputs 1..8 on 8 consecutive cycles, no bubbles, in_ready stays 1.
- Back-pressure: out_ready=0, inputs A then B -> occupancy 2, in_ready=0, input C held. Raise out_ready -> A, B, C emerge in order; in_ready returns to 1 one cycle after the first pop.
- Flush at occupancy 2 with in_valid=1 (D) -> next cycle out_valid=0, out_ctrl=0, occupancy=0; D never appears at the output.
- Async reset pulse mid-stream (rst low for half a cycle) -> out_valid=0 and occupancy=0 immediately, without waiting for a clock edge.
- With PIPE_STAGE_PERF_EN and CNT_W=4: out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=0xF (saturated). A following flush leaves it at 0xF.
